// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add stall/bubble/flush counters.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W   = 96,
    parameter int unsigned CTRL_W   = 24,
    parameter bit          DATA_CLR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_bubble,
    output logic [15:0]       stat_flush
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_d;
    logic [CTRL_W-1:0]   r_main_c;
    logic [DATA_W-1:0]   r_skid_d;
    logic [CTRL_W-1:0]   r_skid_c;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;

    // Outputs are masked while reset is held so nothing leaks mid-reset.
    assign in_ready   = r_in_ready & rst;
    assign out_valid  = (r_state != ST_EMPTY) & rst;
    assign out_ctrl   = out_valid ? r_main_c : '0;
    assign out_data   = (DATA_CLR && !rst) ? '0 : r_main_d;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_TWO;
                        w_ld_skid   = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main_c   <= '0;
            r_skid_c   <= '0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main_c   <= '0;
            r_skid_c   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_ld_main_in) begin
                r_main_c <= in_ctrl;
            end else if (w_ld_main_skid) begin
                r_main_c <= r_skid_c;
            end
            if (w_ld_skid) begin
                r_skid_c <= in_ctrl;
            end
        end
    end

    // Payload only resets/clears when DATA_CLR is set; otherwise it just holds.
    always_ff @(posedge clk) begin
        if (DATA_CLR && (!rst || flush)) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (rst && !flush) begin
            if (w_ld_main_in) begin
                r_main_d <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_d <= r_skid_d;
            end
            if (w_ld_skid) begin
                r_skid_d <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_bubble;
    logic [15:0] r_stat_flush;

    assign stat_stall  = r_stat_stall;
    assign stat_bubble = r_stat_bubble;
    assign stat_flush  = r_stat_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_stall  <= '0;
            r_stat_bubble <= '0;
            r_stat_flush  <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (!out_valid && (r_stat_bubble != '1)) begin
                r_stat_bubble <= r_stat_bubble + 32'd1;
            end
            // Only flushes that actually kill an entry are interesting.
            if (flush && (r_state != ST_EMPTY) && (r_stat_flush != '1)) begin
                r_stat_flush <= r_stat_flush + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed + reference-FIFO bench for pipe_stage_elastic.
// Stats checks compile in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_elastic;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic        flush;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stat_stall;
    logic [31:0] stat_bubble;
    logic [15:0] stat_flush;
`endif

    int n_chk;
    int n_pass;

    logic [31:0] qd[$];
    logic [7:0]  qc[$];

    pipe_stage_elastic #(
        .DATA_W   (32),
        .CTRL_W   (8),
        .DATA_CLR (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stat_stall  (stat_stall),
        .stat_bubble (stat_bubble),
        .stat_flush  (stat_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        logic m_in_fire;
        logic m_out_fire;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        flush = 1'b0;

        // reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_ctrl", out_ctrl, 8'h00);
            chk("rst_in_ready", in_ready, 0);
        end
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // streaming 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(i, 8'hA5);
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
            chk("stream_ctrl", out_ctrl, 8'hA5);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 0);
        chk("stream_drain_ctrl", out_ctrl, 8'h00);

        // backpressure fill
        out_ready = 1'b0;
        push(32'h10, 8'h11);
        chk("bp_main", out_data, 32'h10);
        chk("bp_ready_one", in_ready, 1);
        push(32'h11, 8'h12);
        chk("bp_ready_two", in_ready, 0);
        chk("bp_hold_main", out_data, 32'h10);
        push(32'h12, 8'h13);
        chk("bp_stall_data", out_data, 32'h10);
        chk("bp_stall_ctrl", out_ctrl, 8'h11);
        chk("bp_stall_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("bp_out1_data", out_data, 32'h11);
        chk("bp_out1_ctrl", out_ctrl, 8'h12);
        chk("bp_out1_ready", in_ready, 1);
        tick();
        chk("bp_out2_valid", out_valid, 1);
        chk("bp_out2_data", out_data, 32'h12);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", out_valid, 0);

        // flush while TWO
        out_ready = 1'b0;
        push(32'h20, 8'hFF);
        push(32'h21, 8'hFF);
        chk("fl_two_ready", in_ready, 0);
        chk("fl_two_data", out_data, 32'h20);
        flush = 1'b1;
        push(32'h22, 8'hFF);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ctrl", out_ctrl, 8'h00);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_discard", out_valid, 0);

        // reset mid-operation in TWO
        out_ready = 1'b0;
        push(32'h30, 8'h3C);
        push(32'h31, 8'h3D);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ctrl", out_ctrl, 8'h00);
        chk("mrst_ready", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mrst_no_stale", out_valid, 0);
        chk("mrst_ready_up", in_ready, 1);

        // randomised handshake vs reference FIFO
        do_reset();
        qd.delete();
        qc.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            m_in_fire  = in_valid && (qd.size() < 2);
            m_out_fire = (qd.size() > 0) && out_ready;
            tick();
            if (flush) begin
                qd.delete();
                qc.delete();
            end else begin
                if (m_out_fire) begin
                    void'(qd.pop_front());
                    void'(qc.pop_front());
                end
                if (m_in_fire) begin
                    qd.push_back(in_data);
                    qc.push_back(in_ctrl);
                end
            end
            chk("rnd_valid", out_valid, qd.size() > 0);
            chk("rnd_ready", in_ready, qd.size() < 2);
            if (qd.size() > 0) begin
                chk("rnd_data", out_data, qd[0]);
                chk("rnd_ctrl", out_ctrl, qc[0]);
            end else begin
                chk("rnd_ctrl_bubble", out_ctrl, 8'h00);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
        do_reset();
        out_ready = 1'b0;
        push(32'h40, 8'h44);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stat_stall", stat_stall, 5);
        chk("stat_bubble_min", stat_bubble >= 32'd3, 1);
        chk("stat_flush", stat_flush, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX-style pipeline register; usable between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a separate control field.
- Replaces the global stall input with a valid/ready handshake, and uses a 2-entry skid buffer so in_ready is fully registered.
- Flush converts all held entries into bubbles with zeroed control.

Parameters:
- DATA_W, 96: payload width (PC, immediates, register numbers).
- CTRL_W, 24: control-field width (RegWrite, MemRead, ALU_op, ...). Zeroed on bubble.
- DATA_CLR, 0: 1 = flush and reset also clear the data registers; 0 = data is held and only valid/ctrl are cleared.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-low; one clock.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage can accept an entry; registered.
- in_data, in, DATA_W: upstream payload.
- in_ctrl, in, CTRL_W: upstream control.
- out_valid, out, 1: entry present toward downstream.
- out_ready, in, 1: downstream accepts (hazard-unit stall = !out_ready).
- out_data, out, DATA_W: payload of the head entry.
- out_ctrl, out, CTRL_W: control of the head entry; forced to 0 whenever out_valid=0.
- flush, in, 1: kill all entries (branch mispredict, trap).

Behaviour:
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - Main register (main_v, main_d, main_c) drives the outputs.
  - Skid register (skid_v, skid_d, skid_c).
  - State is encoded as EMPTY (no valids), ONE (main_v only), TWO (main_v and skid_v).
  - skid_v=1 with main_v=0 is illegal and must never occur.
- Reset (rst=0 at a clock edge):
  - State goes to EMPTY; main_c and skid_c are set to 0.
  - Data registers are cleared only if DATA_CLR=1.
  - While rst=0: in_ready=0, out_valid=0, out_ctrl=0, and out_data=0 if DATA_CLR=1.
  - First cycle after release: in_ready=1.
- Priority at each edge: reset, then flush, then handshake.
- Flush:
  - Next state is EMPTY; main_c and skid_c are set to 0; any in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle still counts downstream, because the downstream stage sees the current out_valid.
  - in_ready=1 on the following cycle.
- Transitions (no flush):
  - EMPTY, in_fire: load main, go to ONE.
  - ONE, out_fire and in_fire: load main, stay in ONE.
  - ONE, out_fire only: go to EMPTY.
  - ONE, in_fire only: load skid, go to TWO.
  - ONE, neither: hold.
  - TWO: in_ready=0. On out_fire, main takes skid and the state goes to ONE; otherwise hold.
- in_ready is registered: next in_ready = !(next state == TWO).
- Latency and throughput:
  - Input to output is 1 cycle.
  - Sustained throughput is 1 entry per cycle with out_ready held high.
  - Ordering is strict FIFO.
  - No entry is lost or duplicated under any in_valid/out_ready pattern.
- Stability: while out_valid=1 and out_ready=0, out_data and out_ctrl hold stable.
- Width rules: payload and control pass through bit-exact; no sign extension or truncation.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, the block adds three outputs, each saturating at all-ones and cleared by reset:
  - stat_stall [31:0]: counts cycles with out_valid=1 and out_ready=0.
  - stat_bubble [31:0]: counts cycles with out_valid=0.
  - stat_flush [15:0]: counts flush cycles in which at least one valid entry was killed.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan (DATA_W=32, CTRL_W=8, DATA_CLR=0):
- Reset and streaming:
  - Stimulus: hold rst=0 for 2 cycles, then release.
  - Required: during reset out_valid=0, out_ctrl=0x00, in_ready=0; in_ready=1 on the first post-reset cycle.
  - Stimulus: with out_ready=1, stream data 1..8 and ctrl 0xA5.
  - Required: out_data = 1..8 on consecutive cycles, each 1 cycle after input.
- Backpressure fill:
  - Stimulus: stream 0x10, 0x11, 0x12 with out_ready=0.
  - Required: 0x10 in main, 0x11 in skid; in_ready drops to 0 the cycle after 0x11 is accepted; 0x12 is held upstream.
  - Stimulus: raise out_ready.
  - Required: outputs 0x10, 0x11, 0x12 in order, no gaps after the first.
- Flush in TWO:
  - Stimulus: fill 0x20, 0x21 (ctrl 0xFF); assert flush with in_valid=1 (data 0x22).
  - Required: next cycle out_valid=0 and out_ctrl=0x00; 0x22 discarded; in_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst=0 while in TWO.
  - Required: next cycle EMPTY; out_valid=0; no stale entry appears after release.
- Randomised handshake:
  - Stimulus: 1000 cycles of random in_valid/out_ready plus sparse flush, checked against a reference FIFO with kill-on-flush.
  - Required: exact ordering; data stable while stalled; out_ctrl=0 whenever out_valid=0.
- Stats (PIPE_STAGE_STATS_EN defined):
  - Stimulus: 5 stalled cycles, 3 empty cycles, 1 flush with valid content, 1 flush while empty.
  - Required: stat_stall=5, stat_bubble≥3, stat_flush=1.
